// File: rtl/game_status_ctrl_if.sv
// Game-flow signal bundle between the snake play logic / start button and the status controller.
// slave = the controller, master = whoever drives the button and hit flags.
`timescale 1ns/1ps
interface game_status_ctrl_if;
    logic       key_start_n;
    logic       hit_wall;
    logic       hit_self;
    logic [2:0] Game_status;
    logic       game_reset_pulse;

    modport slave (
        input  key_start_n,
        input  hit_wall,
        input  hit_self,
        output Game_status,
        output game_reset_pulse
    );

    modport master (
        output key_start_n,
        output hit_wall,
        output hit_self,
        input  Game_status,
        input  game_reset_pulse
    );
endinterface

// File: rtl/game_status_ctrl.sv
// One-hot START/PLAY/END sequencer with debounced start key, END dwell/timeout and restart pulse.
// Press-to-status latency DEBOUNCE_CYCLES+3 edges; no backpressure, inputs are sampled every cycle.
`timescale 1ns/1ps
module game_status_ctrl #(
    parameter int DEBOUNCE_CYCLES    = 800000,
    parameter int END_HOLD_CYCLES    = 40000000,
    parameter int END_TIMEOUT_CYCLES = 400000000,
    parameter int CNT_W              = 29
) (
    input logic              CLK_40M,
    input logic              RSTn,
    game_status_ctrl_if.slave gs
);

    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] END_HOLD = CNT_W'(END_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] END_LAST = CNT_W'(END_TIMEOUT_CYCLES - 1);

    logic             sync_ff1;
    logic             sync_key;
    logic             stable_key;
    logic             stable_key_d;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] end_cnt;
    state_t           state;
    logic             reset_pulse_q;
    logic             press_evt;
    logic             hit;

    // Idle level of the button is high, so the chain resets to "released".
    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            sync_ff1     <= 1'b1;
            sync_key     <= 1'b1;
            stable_key   <= 1'b1;
            stable_key_d <= 1'b1;
            deb_cnt      <= '0;
        end else begin
            sync_ff1     <= gs.key_start_n;
            sync_key     <= sync_ff1;
            stable_key_d <= stable_key;
            if (sync_key == stable_key) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                stable_key <= sync_key;
                deb_cnt    <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press_evt = stable_key_d & ~stable_key;
    assign hit       = gs.hit_wall | gs.hit_self;

    // end_cnt defaults to 0 so it is already cleared on every END entry.
    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            state         <= ST_START;
            end_cnt       <= '0;
            reset_pulse_q <= 1'b0;
        end else begin
            reset_pulse_q <= 1'b0;
            end_cnt       <= '0;
            case (state)
                ST_START: begin
                    if (press_evt) begin
                        state         <= ST_PLAY;
                        reset_pulse_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (hit) begin
                        state <= ST_END;
                    end
                end
                ST_END: begin
                    if ((press_evt && (end_cnt >= END_HOLD)) || (end_cnt == END_LAST)) begin
                        state <= ST_START;
                    end else begin
                        end_cnt <= end_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_START;
                end
            endcase
        end
    end

    assign gs.Game_status      = state;
    assign gs.game_reset_pulse = reset_pulse_q;

endmodule
